retire_trace_buf: RTL and testbench

Capture buffer between the writeback/retire stage and the text instruction decoder used for simulation trace.
- Accepts up to NUM_RETIRE retired instructions (word + PC) per cycle.
- Tags each with a retirement sequence number and queues them in order.
- Drains one entry per cycle over a valid/ready handshake to the trace printer, which feeds trc_inst/trc_pc into the text decoder.
- Drops and counts instructions when full, so the pipeline is never stalled.

---
 rtl/trace_pkg.sv | 21 ++
 rtl/retire_trace_buf_if.sv | 24 ++
 rtl/trace_ram.sv | 27 ++
 rtl/retire_trace_buf.sv | 125 ++++++++++++
 tb/tb_retire_trace_buf.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// Shared types and helpers for the retire trace capture buffer.
package trace_pkg;

  localparam int SEQ_W_DEF  = 32;
  localparam int MAX_RETIRE = 8;

  typedef struct packed {
    logic [31:0]          inst;
    logic [31:0]          pc;
    logic [SEQ_W_DEF-1:0] seq;
  } trace_entry_t;

  // Number of set bits in a retire mask (callers zero-extend to MAX_RETIRE).
  function automatic logic [3:0] popcount(input logic [MAX_RETIRE-1:0] mask);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_RETIRE; i++) n = n + {3'b000, mask[i]};
    return n;
  endfunction

endpackage

// File: rtl/retire_trace_buf_if.sv
// Retire-side strobes and trace-side valid/ready bundle for retire_trace_buf.
interface retire_trace_buf_if #(
  parameter int NUM_RETIRE = 2,
  parameter int SEQ_W      = 32
);
  logic [NUM_RETIRE-1:0]       ret_valid;
  logic [NUM_RETIRE-1:0][31:0] ret_inst;
  logic [NUM_RETIRE-1:0][31:0] ret_pc;
  logic                        trc_valid;
  logic                        trc_ready;
  logic [31:0]                 trc_inst;
  logic [31:0]                 trc_pc;
  logic [SEQ_W-1:0]            trc_seq;

  modport master (
    output ret_valid, ret_inst, ret_pc, trc_ready,
    input  trc_valid, trc_inst, trc_pc, trc_seq
  );

  modport slave (
    input  ret_valid, ret_inst, ret_pc, trc_ready,
    output trc_valid, trc_inst, trc_pc, trc_seq
  );
endinterface

// File: rtl/trace_ram.sv
// Trace entry storage: several write ports, one asynchronous read port, no reset.
module trace_ram
  import trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int NUM_WR = 2
) (
  input  logic                                    clk_i,
  input  logic [NUM_WR-1:0]                       we_i,
  input  logic [NUM_WR-1:0][$clog2(DEPTH)-1:0]    waddr_i,
  input  trace_entry_t [NUM_WR-1:0]               wdata_i,
  input  logic [$clog2(DEPTH)-1:0]                raddr_i,
  output trace_entry_t                            rdata_o
);

  trace_entry_t mem_q [DEPTH];

  // Enabled write addresses within one cycle are always distinct.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_WR; i++) begin
      if (we_i[i]) mem_q[waddr_i[i]] <= wdata_i[i];
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/retire_trace_buf.sv
// Show-ahead capture FIFO between retire and the trace printer; drops (never stalls) when full.
module retire_trace_buf
  import trace_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int NUM_RETIRE = 2,
  parameter int SEQ_W      = SEQ_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     capture_en,
  input  logic                     flush,
  retire_trace_buf_if.slave        bus,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [SEQ_W-1:0]         dropped_cnt,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d, occ_q, occ_d;
  logic [SEQ_W-1:0] seq_q, seq_d, drop_q, drop_d;
  logic             ovf_q, ovf_d;

  logic [PW-1:0]                   free, k, n_push, n_drop;
  logic                            pop;
  logic [NUM_RETIRE-1:0]           we;
  logic [NUM_RETIRE-1:0][AW-1:0]   waddr;
  trace_entry_t [NUM_RETIRE-1:0]   wdata;
  trace_entry_t                    head;

  function automatic logic [SEQ_W-1:0] sat_add(input logic [SEQ_W-1:0] a,
                                                input logic [PW-1:0]    b);
    logic [SEQ_W:0] sum;
    sum = {1'b0, a} + (SEQ_W+1)'(b);
    return sum[SEQ_W] ? '1 : sum[SEQ_W-1:0];
  endfunction

  always_comb begin
    free   = PW'(DEPTH) - occ_q;
    pop    = (occ_q != '0) && bus.trc_ready && !flush;
    we     = '0;
    waddr  = '0;
    wdata  = '0;
    k      = '0;
    n_push = '0;
    n_drop = '0;
    // k walks the valid slots so seq numbers and write addresses stay compacted.
    for (int s = 0; s < NUM_RETIRE; s++) begin
      wdata[s].inst = bus.ret_inst[s];
      wdata[s].pc   = bus.ret_pc[s];
      wdata[s].seq  = seq_q + SEQ_W'(k);
      waddr[s]      = wr_q[AW-1:0] + k[AW-1:0];
      if (bus.ret_valid[s]) begin
        if (capture_en && !flush) begin
          if (k < free) begin
            we[s]  = 1'b1;
            n_push = n_push + PW'(1);
          end else begin
            n_drop = n_drop + PW'(1);
          end
        end
        k = k + PW'(1);
      end
    end

    seq_d  = seq_q + SEQ_W'(popcount(MAX_RETIRE'(bus.ret_valid)));
    drop_d = sat_add(drop_q, n_drop);
    ovf_d  = ovf_q | (n_drop != '0);
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      occ_d = '0;
    end else begin
      wr_d  = wr_q + n_push;
      rd_d  = rd_q + PW'(pop);
      occ_d = occ_q + n_push - PW'(pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      occ_q  <= '0;
      seq_q  <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      occ_q  <= occ_d;
      seq_q  <= seq_d;
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
    end
  end

  trace_ram #(.DEPTH(DEPTH), .NUM_WR(NUM_RETIRE)) u_ram (
    .clk_i   (clock),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (rd_q[AW-1:0]),
    .rdata_o (head)
  );

  // Stale storage is masked so an empty buffer always presents zeros.
  assign bus.trc_valid = (occ_q != '0);
  assign bus.trc_inst  = bus.trc_valid ? head.inst : '0;
  assign bus.trc_pc    = bus.trc_valid ? head.pc   : '0;
  assign bus.trc_seq   = bus.trc_valid ? SEQ_W'(head.seq) : '0;
  assign occupancy     = occ_q;
  assign dropped_cnt   = drop_q;
  assign overflow      = ovf_q;

  a_occ_bound : assert property (@(posedge clock) disable iff (reset)
    occ_q <= PW'(DEPTH));

  a_head_stable : assert property (@(posedge clock) disable iff (reset)
    (bus.trc_valid && !bus.trc_ready && !flush)
      |=> $stable({bus.trc_inst, bus.trc_pc, bus.trc_seq}));

endmodule

// File: tb/tb_retire_trace_buf.sv
// Directed + short random bench for retire_trace_buf with a queue scoreboard.
module tb_retire_trace_buf;

  localparam int DEPTH = 16;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] seq;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        capture_en;
  logic        flush;
  logic [4:0]  occupancy;
  logic [31:0] dropped_cnt;
  logic        overflow;

  retire_trace_buf_if #(.NUM_RETIRE(2), .SEQ_W(32)) bus ();

  retire_trace_buf #(.DEPTH(DEPTH), .NUM_RETIRE(2), .SEQ_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .capture_en  (capture_en),
    .flush       (flush),
    .bus         (bus),
    .occupancy   (occupancy),
    .dropped_cnt (dropped_cnt),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  exp_t        sb[$];
  int          nerr = 0;
  int          nchk = 0;
  logic [31:0] mseq = 0;
  logic [31:0] mdrop = 0;
  logic        movf = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Entered just after a rising edge; drives one cycle and updates the model.
  task automatic step(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [31:0] p0, input logic [31:0] p1,
                      input logic rdy, input logic cap, input logic fl);
    int   free_n;
    int   idx;
    exp_t e;
    bus.ret_valid   = v;
    bus.ret_inst[0] = i0;
    bus.ret_inst[1] = i1;
    bus.ret_pc[0]   = p0;
    bus.ret_pc[1]   = p1;
    bus.trc_ready   = rdy;
    capture_en      = cap;
    flush           = fl;
    @(negedge clock);
    chk("trc_valid", 64'(bus.trc_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("head_inst", 64'(bus.trc_inst), 64'(sb[0].inst));
      chk("head_pc",   64'(bus.trc_pc),   64'(sb[0].pc));
      chk("head_seq",  64'(bus.trc_seq),  64'(sb[0].seq));
    end else begin
      chk("idle_inst", 64'(bus.trc_inst), 64'(0));
      chk("idle_seq",  64'(bus.trc_seq),  64'(0));
    end
    free_n = DEPTH - sb.size();
    if (fl) sb.delete();
    else if (rdy && sb.size() != 0) void'(sb.pop_front());
    idx = 0;
    for (int s = 0; s < 2; s++) begin
      if (v[s]) begin
        if (cap && !fl) begin
          if (idx < free_n) begin
            e.inst = (s == 1) ? i1 : i0;
            e.pc   = (s == 1) ? p1 : p0;
            e.seq  = mseq + 32'(idx);
            sb.push_back(e);
          end else begin
            if (mdrop != 32'hFFFF_FFFF) mdrop = mdrop + 1;
            movf = 1'b1;
          end
        end
        idx++;
      end
    end
    mseq = mseq + 32'(idx);
    @(posedge clock);
    #1;
    chk("occupancy", 64'(occupancy),   64'(sb.size()));
    chk("dropped",   64'(dropped_cnt), 64'(mdrop));
    chk("overflow",  64'(overflow),    64'(movf));
  endtask

  initial begin
    reset         = 1'b1;
    capture_en    = 1'b0;
    flush         = 1'b0;
    bus.ret_valid = '0;
    bus.ret_inst  = '0;
    bus.ret_pc    = '0;
    bus.trc_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_occ",   64'(occupancy),     64'(0));
    chk("rst_valid", 64'(bus.trc_valid), 64'(0));
    chk("rst_inst",  64'(bus.trc_inst),  64'(0));
    chk("rst_drop",  64'(dropped_cnt),   64'(0));
    chk("rst_ovf",   64'(overflow),      64'(0));

    // Two-wide retire, then pop one.
    step(2'b11, 32'h0000_0000, 32'h2402_0005, 32'h400, 32'h404, 1'b0, 1'b1, 1'b0);
    chk("t1_occ",  64'(occupancy),    64'(2));
    chk("t1_inst", 64'(bus.trc_inst), 64'(32'h0000_0000));
    chk("t1_pc",   64'(bus.trc_pc),   64'(32'h400));
    chk("t1_seq",  64'(bus.trc_seq),  64'(0));
    step(2'b00, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    chk("t1p_inst", 64'(bus.trc_inst), 64'(32'h2402_0005));
    chk("t1p_pc",   64'(bus.trc_pc),   64'(32'h404));
    chk("t1p_seq",  64'(bus.trc_seq),  64'(1));

    // Non-contiguous mask: only slot 1.
    step(2'b10, 32'hDEAD_BEEF, 32'h8FA4_0010, 32'h0, 32'h408, 1'b0, 1'b1, 1'b0);
    chk("t2_occ", 64'(occupancy), 64'(2));

    // Fill to 15, then overflow.
    for (int i = 0; i < 6; i++)
      step(2'b11, 32'h1000 + 32'(2*i), 32'h1001 + 32'(2*i),
           32'h500 + 32'(8*i), 32'h504 + 32'(8*i), 1'b0, 1'b1, 1'b0);
    step(2'b01, 32'h2000, 32'h0, 32'h600, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("t3_occ15", 64'(occupancy), 64'(15));
    step(2'b11, 32'h2001, 32'h2002, 32'h604, 32'h608, 1'b0, 1'b1, 1'b0);
    chk("t3_occ16", 64'(occupancy),   64'(16));
    chk("t3_drop1", 64'(dropped_cnt), 64'(1));
    chk("t3_ovf",   64'(overflow),    64'(1));
    step(2'b11, 32'h2003, 32'h2004, 32'h60C, 32'h610, 1'b0, 1'b1, 1'b0);
    chk("t3_drop3", 64'(dropped_cnt), 64'(3));

    // Full with a same-cycle pop: the pop does not make room.
    step(2'b01, 32'h2005, 32'h0, 32'h614, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("t4_occ",  64'(occupancy),   64'(15));
    chk("t4_drop", 64'(dropped_cnt), 64'(4));

    // Drain to 8, then flush alongside push and pop.
    repeat (7) step(2'b00, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    chk("t5_pre", 64'(occupancy), 64'(8));
    step(2'b11, 32'h3000, 32'h3001, 32'h700, 32'h704, 1'b1, 1'b1, 1'b1);
    chk("t5_occ",   64'(occupancy),     64'(0));
    chk("t5_valid", 64'(bus.trc_valid), 64'(0));
    chk("t5_inst",  64'(bus.trc_inst),  64'(0));
    chk("t5_ovf",   64'(overflow),      64'(1));
    chk("t5_drop",  64'(dropped_cnt),   64'(4));

    // Capture disabled: seq advances, nothing stored or dropped.
    repeat (3) step(2'b11, 32'h4000, 32'h4001, 32'h800, 32'h804, 1'b0, 1'b0, 1'b0);
    step(2'b01, 32'h4100, 32'h0, 32'h900, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("t6_occ",  64'(occupancy),   64'(1));
    chk("t6_seq",  64'(bus.trc_seq), 64'(29));
    chk("t6_inst", 64'(bus.trc_inst), 64'(32'h4100));
    chk("t6_drop", 64'(dropped_cnt), 64'(4));

    // Random mix of masks and back-pressure.
    for (int i = 0; i < 40; i++)
      step(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
           1'($urandom_range(0, 1)), 1'b1, 1'b0);
    step(2'b11, 32'h5000, 32'h5001, 32'hA00, 32'hA04, 1'b0, 1'b1, 1'b0);

    // Async reset mid-drain, checked before the next edge.
    bus.trc_ready = 1'b1;
    bus.ret_valid = 2'b00;
    #3;
    reset = 1'b1;
    #1;
    chk("ar_valid", 64'(bus.trc_valid), 64'(0));
    chk("ar_inst",  64'(bus.trc_inst),  64'(0));
    chk("ar_pc",    64'(bus.trc_pc),    64'(0));
    chk("ar_seq",   64'(bus.trc_seq),   64'(0));
    chk("ar_occ",   64'(occupancy),     64'(0));
    chk("ar_drop",  64'(dropped_cnt),   64'(0));
    chk("ar_ovf",   64'(overflow),      64'(0));
    sb.delete();
    mseq  = 0;
    mdrop = 0;
    movf  = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(2'b01, 32'h1111_1111, 32'h0, 32'h500, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("post_seq", 64'(bus.trc_seq), 64'(0));
    chk("post_occ", 64'(occupancy),   64'(1));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
